// File: rtl/fifo_8to16.sv
// Single-clock byte FIFO with registered read data and full/empty flags.
// Define FIFO_FWFT_EN for first-word fall-through (head word shown combinationally).
module fifo_8to16 #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              rd_ok, wr_ok;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // A write while full is only accepted when a read frees the slot on the same edge.
  always_comb begin
    rd_ok    = re && !empty;
    wr_ok    = we && (!full || re);
    wr_ptr_d = wr_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (wr_ok && !rd_ok)      count_d = count_q + CNT_ONE;
    else if (rd_ok && !wr_ok) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; stale words are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) mem_q[wr_ptr_q] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out = empty ? '0 : mem_q[rd_ptr_q];
`else
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (reset)      dout_q <= '0;
    else if (rd_ok) dout_q <= mem_q[rd_ptr_q];
  end

  assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_fifo_8to16.sv
// Randomized bench for fifo_8to16: queue-based reference model checked every cycle,
// plus directed literal expectations from the block's test plan.
module tb_fifo_8to16;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       we = 1'b0, re = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       full, empty;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [7:0] m_q[$];
  logic [7:0] m_dout = '0;

  fifo_8to16 dut (
    .clk(clk), .reset(reset), .we(we), .re(re), .data_in(data_in),
    .data_out(data_out), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Reference: pop before push, so a simultaneous read returns the old head.
  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_dout = '0;
    end else begin
      bit rd, wr;
      rd = re && (m_q.size() > 0);
      wr = we && ((m_q.size() < 16) || re);
      if (rd) m_dout = m_q.pop_front();
      if (wr) m_q.push_back(data_in);
    end
  end

  function automatic logic [7:0] exp_dout();
`ifdef FIFO_FWFT_EN
    return (m_q.size() > 0) ? m_q[0] : 8'd0;
`else
    return m_dout;
`endif
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (data_out !== exp_dout() || empty !== (m_q.size() == 0) || full !== (m_q.size() == 16)) begin
        n_bad++;
        $display("FAIL cycle_check t=%0t: got dout=%0d empty=%b full=%b, want dout=%0d empty=%b full=%b",
                 $time, data_out, empty, full, exp_dout(), (m_q.size() == 0), (m_q.size() == 16));
      end
    end
  end

  task automatic step(input bit w, input bit r, input logic [7:0] d);
    we = w; re = r; data_in = d;
    @(posedge clk); #2;
  endtask

  task automatic lit(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin
    int seq[6];
    logic [7:0] wv;
    seq = '{10, 12, 15, 17, 14, 13};
    #2;
    reset = 1'b1;
    step(0, 0, 0);
    reset = 1'b0;
    chk_en = 1'b1;
    lit("reset_empty", int'(empty), 1);
    lit("reset_full", int'(full), 0);
    lit("reset_dout", int'(data_out), 0);

`ifdef FIFO_FWFT_EN
    step(1, 0, 42);
    lit("fwft_head", int'(data_out), 42);
    step(0, 1, 0);
    lit("fwft_empty", int'(empty), 1);
    lit("fwft_dout0", int'(data_out), 0);
`else
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 8'(seq[i]));
      if (i == 0) lit("first_write_empty", int'(empty), 0);
    end
    lit("six_full", int'(full), 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0);
      lit($sformatf("read_%0d", i), int'(data_out), seq[i]);
    end
    lit("one_left_empty", int'(empty), 0);

    for (int i = 0; i < 3; i++) begin
      step(1, 1, 9);
      lit($sformatf("rw_dout_%0d", i), int'(data_out), (i == 0) ? 13 : 9);
      lit("rw_model_count", m_q.size(), 1);
    end
    for (int i = 0; i < 3; i++) step(1, 0, 9);
    lit("model_count4", m_q.size(), 4);
    lit("count4_empty", int'(empty), 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    lit("drained", int'(empty), 1);

    for (int i = 0; i < 16; i++) step(1, 0, 8'(i));
    lit("fill_full", int'(full), 1);
    step(1, 0, 99);
    lit("drop_full", int'(full), 1);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0);
      lit($sformatf("fill_rd_%0d", i), int'(data_out), i);
    end
    lit("fill_rd_empty", int'(empty), 1);

    step(0, 1, 0);
    lit("empty_rd_hold", int'(data_out), 15);
    lit("empty_rd_empty", int'(empty), 1);

    for (int i = 0; i < 24; i++) begin
      wv = 8'($urandom);
      step(1, 0, wv);
      step(0, 1, 0);
      lit($sformatf("wrap_%0d", i), int'(data_out), int'(wv));
    end
`endif

    // Random traffic with a varying fill bias and occasional mid-stream resets.
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = ((i / 300) % 2 == 0) ? 70 : 30;
      reset = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias), 8'($urandom));
    end
    reset = 1'b0;
    step(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
